// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the fetch port and the
// data port. Data wins by default; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants made while fetch was waiting.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    // data port
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              err,
    // memory side
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    typedef enum logic [1:0] {StIdle, StIfWait, StDmWait} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              err_q, err_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic if_pend, dm_pend_raw, dm_pend, dm_pri, grant_dm, grant_if;

    // Request masking and grant priority, evaluated only while idle.
    always_comb begin
        if_pend     = if_req & ~if_done_q;
        dm_pend_raw = dm_rd | dm_wr;
        dm_pend     = dm_pend_raw & ~dm_done_q;
        dm_pri      = ~if_pend | (starve_q < StarveMax);
        grant_dm    = dm_pend & dm_pri;
        // A data port with priority that is only masked by its own done still blocks fetch,
        // leaving a one-cycle bubble so back-to-back data accesses count toward starvation.
        grant_if    = if_pend & ~(dm_pend_raw & dm_pri);
    end

    // Next-state, transaction sequencing and starvation bookkeeping.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        err_d       = err_q | (dm_rd & dm_wr);
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (grant_dm) begin
                    state_d     = StDmWait;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = dm_wr;  // rd+wr together is treated as a write
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (if_req && starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (grant_if) begin
                    state_d     = StIfWait;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = 4'd0;
                end
            end
            StIfWait: begin
                if (mem_done) begin
                    state_d = StIdle;
                    // A withdrawn fetch (redirect) completes silently.
                    if (if_req) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            StDmWait: begin
                if (mem_done) begin
                    state_d = StIdle;
                    if (dm_pend_raw) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = mem_wr_q ? '0 : mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!if_req) begin
            starve_d = 4'd0;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            starve_q    <= 4'd0;
            err_q       <= 1'b0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            err_q       <= err_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_done   = dm_done_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Stalls are forced low during reset so every output reads 0 while rst is high.
    assign if_stall = ~rst & if_req & ~if_done_q;
    assign dm_stall = ~rst & (dm_rd | dm_wr) & ~dm_done_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the fetch port (instruction reads) and the data-memory port (loads/stores) of the 16-bit pipelined core.
- Sequences every memory transaction and raises per-port stalls that the pipeline uses to freeze the PC and the pipeline registers.
- Data port has priority; a starvation counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; range 1–15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch read request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; valid while if_done=1.
- if_done  out  1  fetch completion pulse.
- if_stall  out  1  fetch must hold PC.
- dm_rd  in  1  data read request; level.
- dm_wr  in  1  data write request; level.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_done=1.
- dm_done  out  1  data completion pulse.
- dm_stall  out  1  memory stage must hold.
- err  out  1  sticky; set when dm_rd and dm_wr are high together.
- mem_en  out  1  start pulse to memory.
- mem_wr  out  1  write select.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid while mem_done=1.
- mem_done  in  1  memory completion pulse; arrives 1 or more cycles after mem_en.

Behaviour:
- Reset (async, any state): state=IDLE, starve_cnt=0, err=0. All outputs are 0, including rdata and mem_* regs.
- The memory transaction in flight at reset is abandoned. A mem_done arriving in IDLE is ignored.
- FSM states: IDLE, IF_WAIT, DM_WAIT.
- IDLE, request masking: a port whose done output is high this cycle is masked, so its held request is not re-granted.
- IDLE, grant priority:
  - Grant data if a data request is pending and (no fetch request or starve_cnt<STARVE_MAX).
  - Otherwise grant fetch if requested.
  - Otherwise stay in IDLE.
- On grant, at the next edge:
  - state goes to IF_WAIT or DM_WAIT.
  - mem_en=1 for exactly one cycle.
  - mem_addr, mem_wr, mem_wdata are latched from the granted port and held stable until completion.
- WAIT state, on mem_done=1, at the next edge:
  - The owning port's done=1 for one cycle and its rdata is registered from mem_rdata.
  - For writes, dm_rdata is loaded with 0.
  - state goes to IDLE.
- Minimum latency: request seen in cycle t → mem_en in t+1 → mem_done no earlier than t+2 → done in t+3.
- Back-to-back service: earliest next grant is decided in the IDLE cycle where done is high; mem_en for it follows one cycle later.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on each data grant made while if_req=1.
  - Clears on a fetch grant, or in any cycle with if_req=0.
- Stalls (combinational from registered state):
  - if_stall = if_req & ~if_done.
  - dm_stall = (dm_rd|dm_wr) & ~dm_done.
- dm_rd and dm_wr high together: treated as a write; err set and held until reset.
- Fetch redirect: if if_req is 0 in the cycle mem_done arrives in IF_WAIT, the transaction completes but if_done stays 0 and if_rdata is unchanged.
  - The same rule applies to the data port.
- Request inputs are sampled only in IDLE; address changes while in a WAIT state are ignored.
- No combinational path exists from any input to mem_*.

Test Plan:
- Single fetch: rst, then if_req=1, if_addr=0x0010. Memory returns mem_done 2 cycles after mem_en with data 0x1234. Required: mem_addr=0x0010, mem_wr=0; if_done 1 cycle with if_rdata=0x1234; if_stall drops that cycle.
- Simultaneous requests: if_req=1 and dm_wr=1 with dm_addr=0x0200, dm_wdata=0xBEEF, both in the same cycle. Required: the data write is served first (mem_wr=1, mem_wdata=0xBEEF); fetch is granted in the IDLE cycle after dm_done; if_stall stays high throughout.
- Starvation: if_req held while the data port issues 6 back-to-back reads, STARVE_MAX=4. Required: grant order D,D,D,D,F,D,D; starve_cnt is 0 after the F grant.
- Redirect: if_req deasserted in IF_WAIT before a mem_done carrying 0xAAAA. Required: if_done stays 0, if_rdata unchanged; the next fetch to 0x0040 proceeds normally.
- Reset mid-transaction: rst asserted in DM_WAIT. Required: all outputs are 0 immediately (async); a late mem_done pulse after release produces no dm_done.
- Illegal op: dm_rd=1 and dm_wr=1, dm_addr=0x0008. Required: write issued (mem_wr=1); err=1 and stays 1 until rst.
